// File: rtl/cpu_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_div_pkg
// Brief    : Shared constants and state encoding for the iterative divider.
// Revision : 1.0
// ============================================================================
package cpu_div_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 3;
  localparam int DIV_CNT_W   = $clog2(DIV_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } div_state_e;

endpackage
`default_nettype wire

// File: rtl/cpu_div_step.sv
`default_nettype none
// ============================================================================
// Module   : cpu_div_step
// Brief    : One combinational restoring-division step (one quotient bit).
// Revision : 1.0
// ============================================================================
module cpu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_dvd_msb,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;
  logic [WIDTH:0] w_next;
  logic           w_unused_top;

  // Remainder stays below the divisor, so WIDTH+1 bits hold the trial sign.
  assign w_shift      = {i_rem, i_dvd_msb};
  assign w_trial      = w_shift - {1'b0, i_div};
  assign o_qbit       = ~w_trial[WIDTH];
  assign w_next       = o_qbit ? w_trial : w_shift;
  assign o_rem        = w_next[WIDTH-1:0];
  assign w_unused_top = w_next[WIDTH];

endmodule
`default_nettype wire

// File: rtl/cpu_div_cell.sv
`default_nettype none
// ============================================================================
// Module   : cpu_div_cell
// Brief    : Iterative restoring div/divu, one quotient bit per clock.
// Revision : 1.0
// ============================================================================
module cpu_div_cell
  import cpu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] E_src1,
  input  logic [WIDTH-1:0] E_src2,
  input  logic             E_div_start,
  input  logic             E_div_signed,
  input  logic             M_flush,
  output logic             M_div_busy,
  output logic             M_div_done,
  output logic [WIDTH-1:0] M_div_quot,
  output logic [WIDTH-1:0] M_div_rem,
  output logic             M_div_dz
);

  localparam int                 c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

  div_state_e r_state;
  div_state_e w_state_nxt;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_signed;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_bmag;
  logic [WIDTH-1:0]   r_prem;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz_pend;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_rem;
  logic               r_dz;

  logic               w_accept;
  logic [WIDTH-1:0]   w_step_rem;
  logic               w_step_q;

  cpu_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem     (r_prem),
    .i_dvd_msb (r_dvd[WIDTH-1]),
    .i_div     (r_bmag),
    .o_rem     (w_step_rem),
    .o_qbit    (w_step_q)
  );

  // Flush takes priority over a coincident start.
  assign w_accept = E_div_start & ~M_flush &
                    ((r_state == ST_IDLE) | (r_state == ST_DONE));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_PREP;
      ST_PREP: w_state_nxt = M_flush ? ST_IDLE : ST_ITER;
      ST_ITER: begin
        if (M_flush)               w_state_nxt = ST_IDLE;
        else if (r_cnt == '0)      w_state_nxt = ST_FIX;
      end
      ST_FIX:  w_state_nxt = M_flush ? ST_IDLE : ST_DONE;
      ST_DONE: w_state_nxt = w_accept ? ST_PREP : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_signed  <= 1'b0;
      r_dvd     <= '0;
      r_bmag    <= '0;
      r_prem    <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz_pend <= 1'b0;
      r_cnt     <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_dz      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a      <= E_src1;
        r_b      <= E_src2;
        r_signed <= E_div_signed;
      end
      case (r_state)
        ST_PREP: begin
          // Magnitude of MIN_INT wraps to 2^(WIDTH-1), which is correct unsigned.
          r_dvd     <= (r_signed & r_a[WIDTH-1]) ? -r_a : r_a;
          r_bmag    <= (r_signed & r_b[WIDTH-1]) ? -r_b : r_b;
          r_neg_q   <= r_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_neg_r   <= r_signed & r_a[WIDTH-1];
          r_dz_pend <= (r_b == '0);
          r_prem    <= '0;
          r_cnt     <= c_CNT_LAST;
        end
        ST_ITER: begin
          r_prem <= w_step_rem;
          r_dvd  <= {r_dvd[WIDTH-2:0], w_step_q};
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        ST_FIX: begin
          if (!M_flush) begin
            r_dz <= r_dz_pend;
            if (r_dz_pend) begin
              r_quot <= '1;
              r_rem  <= r_a;
            end else begin
              r_quot <= r_neg_q ? -r_dvd  : r_dvd;
              r_rem  <= r_neg_r ? -r_prem : r_prem;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign M_div_busy = (r_state == ST_PREP) | (r_state == ST_ITER) | (r_state == ST_FIX);
  assign M_div_done = (r_state == ST_DONE);
  assign M_div_quot = r_quot;
  assign M_div_rem  = r_rem;
  assign M_div_dz   = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_cpu_div_cell.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_div_cell
// Brief    : Scoreboard bench for cpu_div_cell against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_cpu_div_cell;

  logic        clk;
  logic        reset;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        start;
  logic        sgn;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        dz;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          s;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;
  logic        last_dz = 1'b0;

  cpu_div_cell #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .E_src1       (src1),
    .E_src2       (src2),
    .E_div_start  (start),
    .E_div_signed (sgn),
    .M_flush      (flush),
    .M_div_busy   (busy),
    .M_div_done   (done),
    .M_div_quot   (quot),
    .M_div_rem    (rem),
    .M_div_dz     (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sbv;
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else if (!s) begin
      q = a / b; r = a % b; z = 1'b0;
    end else begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      q = 32'(sa / sbv); r = 32'(sa % sbv); z = 1'b0;
    end
  endtask

  // Called at a negedge; returns one negedge later with start released.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit s, input bit track);
    exp_t e;
    src1 = a; src2 = b; sgn = s; start = 1'b1;
    if (track) begin
      e.a = a; e.b = b; e.s = s; e.cyc = cyc + 35;
      ref_div(a, b, s, e.q, e.r, e.dz);
      sb.push_back(e);
      last_q = e.q; last_r = e.r; last_dz = e.dz;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("quot", quot, e.q);
        chk("rem", rem, e.r);
        chk("dz", {31'd0, dz}, {31'd0, e.dz});
        chk("latency", cyc, e.cyc);
        if (!e.dz) chk("identity", quot * e.b + rem, e.a);
      end
    end
  end

  function automatic logic [31:0] pick();
    logic [31:0] specials [5];
    specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    case ($urandom_range(0, 3))
      0:       return specials[$urandom_range(0, 4)];
      1:       return 32'($urandom_range(0, 255)) * (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h1);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nbusy;
    bit early;
    bit seen;
    reset = 1'b1; src1 = '0; src2 = '0; start = 1'b0; sgn = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quot", quot, 32'd0);
    chk("rst_rem", rem, 32'd0);
    chk("rst_dz", {31'd0, dz}, 32'd0);
    @(negedge clk);

    // divu 100/7 with busy/done timing profile
    issue(32'd100, 32'd7, 1'b0, 1'b1);
    nbusy = 0; early = 1'b0;
    for (int n = 1; n <= 34; n++) begin
      if (n > 1) @(negedge clk);
      if (busy) nbusy++;
      if (done) early = 1'b1;
    end
    @(negedge clk);
    chk("busy_cycles", nbusy, 34);
    chk("done_early", {31'd0, early}, 32'd0);
    chk("done_at_35", {31'd0, done}, 32'd1);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    wait_drain();

    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1); wait_drain();
    issue(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1); wait_drain();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1); wait_drain();
    issue(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1); wait_drain();

    // Start during ITER is ignored; start on the done cycle is accepted.
    issue(32'd50, 32'd5, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    issue(32'd9, 32'd3, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    issue(32'd9, 32'd3, 1'b0, 1'b1);
    wait_drain();

    // Flush mid-operation
    issue(32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_quot", quot, last_q);
    chk("flush_rem", rem, last_r);
    chk("flush_dz", {31'd0, dz}, {31'd0, last_dz});
    repeat (40) @(negedge clk);

    // Flush coincident with start drops the start
    flush = 1'b1;
    issue(32'd77, 32'd7, 1'b0, 1'b0);
    flush = 1'b0;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);

    // Reset mid-operation
    issue(32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (18) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_quot", quot, 32'd0);
    chk("mrst_rem", rem, 32'd0);
    chk("mrst_dz", {31'd0, dz}, 32'd0);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      issue(pick(), pick(), 1'($urandom_range(0, 1)), 1'b1);
      wait_drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
